// File: rtl/plic_pkg.sv
// Shared PLIC types, limits and ID-width helper.
package plic_pkg;

    localparam int IRQ_NUM_MAX    = 1024;
    localparam int IRQ_ID_MAX_W   = 10;
    localparam int IRQ_PRIO_MAX_W = 8;

    typedef logic [IRQ_ID_MAX_W-1:0]   irq_id_t;
    typedef logic [IRQ_PRIO_MAX_W-1:0] irq_prio_t;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/plic_target_ctrl_if.sv
// Gateway-side bundle: per-source request/accept and completion pulses.
interface plic_target_ctrl_if #(
    parameter int IRQ_NUM = 3
);
    logic [IRQ_NUM-1:0] valid;
    logic [IRQ_NUM-1:0] ready;
    logic [IRQ_NUM-1:0] comp;

    modport master (output valid, input  ready, input  comp);
    modport slave  (input  valid, output ready, output comp);
endinterface

// File: rtl/plic_max_sel.sv
// Max-priority finder over eligible sources, binary reduction tree.
// Latency: combinational. Backpressure: none.
// Ties resolve to the lower ID because the left (lower) child wins equal compares.
module plic_max_sel #(
    parameter int N  = 3,
    parameter int PW = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]         elig_i,
    input  logic [N-1:0][PW-1:0] prio_i,
    output logic [IW-1:0]        max_id_o,
    output logic [PW-1:0]        max_prio_o
);
    localparam int LEAVES = 1 << $clog2(N);

    logic [PW-1:0] node_prio [LEAVES];
    logic [IW-1:0] node_id   [LEAVES];

    // Level-by-level reduction done in place: node j of a level reads 2j/2j+1,
    // which are never overwritten before being consumed.
    always_comb begin
        node_prio = '{default: '0};
        node_id   = '{default: '0};
        for (int i = 0; i < N; i++) begin
            node_prio[i] = elig_i[i] ? prio_i[i] : '0;
            node_id[i]   = IW'(i);
        end
        for (int w = LEAVES / 2; w >= 1; w = w / 2) begin
            for (int j = 0; j < w; j++) begin
                if (node_prio[2*j+1] > node_prio[2*j]) begin
                    node_prio[j] = node_prio[2*j+1];
                    node_id[j]   = node_id[2*j+1];
                end else begin
                    node_prio[j] = node_prio[2*j];
                    node_id[j]   = node_id[2*j];
                end
            end
        end
    end

    assign max_id_o   = node_id[0];
    assign max_prio_o = node_prio[0];

endmodule

// File: rtl/plic_target_ctrl.sv
// Per-target PLIC core: pending latch, priority resolve, threshold, claim/complete.
// Latency: handshake -> ext_irq_o in 3 edges; claim_id_o/comp_o combinational.
// Backpressure: ready_o[i] low while source i is pending; irq0 never accepted.
module plic_target_ctrl
    import plic_pkg::*;
#(
    parameter int IRQ_NUM        = 3,
    parameter int IRQ_PRIO_WIDTH = 3,
    parameter int ID_WIDTH       = id_width(IRQ_NUM)
) (
    input  logic                                    clk_i,
    input  logic                                    rst_n_i,
    plic_target_ctrl_if.slave                       gw,
    input  logic [IRQ_NUM-1:0][IRQ_PRIO_WIDTH-1:0]  prio_i,
    input  logic [IRQ_NUM-1:0]                      ie_i,
    input  logic [IRQ_PRIO_WIDTH-1:0]               thold_i,
    output logic [IRQ_NUM-1:0]                      ip_o,
    input  logic                                    claim_i,
    output logic [ID_WIDTH-1:0]                     claim_id_o,
    input  logic                                    comp_i,
    input  logic [ID_WIDTH-1:0]                     comp_id_i,
    output logic                                    ext_irq_o
);
    logic [IRQ_NUM-1:0]        ip_q, ip_d, act_q, act_d;
    logic [IRQ_NUM-1:0]        elig, ready, claim_oh, comp_oh;
    logic [ID_WIDTH-1:0]       best_id_q, best_id_d;
    logic [IRQ_PRIO_WIDTH-1:0] best_prio_q, best_prio_d;
    logic                      ext_irq_q, ext_irq_d;
    logic                      claim_ok, comp_ok, comp_in_range;

    always_comb begin
        elig = '0;
        for (int i = 0; i < IRQ_NUM; i++) begin
            elig[i] = ip_q[i] & ie_i[i] & (prio_i[i] != '0);
        end
    end

    assign ready    = {~ip_q[IRQ_NUM-1:1], 1'b0};
    assign gw.ready = ready;

    // Re-checking elig of the registered winner stops a claim in the cycle after
    // a previous claim from returning the same, already cleared, ID.
    assign claim_ok   = rst_n_i & (best_prio_q > thold_i) & elig[best_id_q];
    assign claim_id_o = claim_ok ? best_id_q : '0;

    assign comp_in_range = ({1'b0, comp_id_i} < (ID_WIDTH + 1)'(IRQ_NUM));
    assign comp_ok       = rst_n_i & comp_i & (comp_id_i != '0) & comp_in_range
                           & act_q[comp_id_i];

    always_comb begin
        claim_oh = '0;
        comp_oh  = '0;
        for (int i = 0; i < IRQ_NUM; i++) begin
            claim_oh[i] = claim_i & claim_ok & (best_id_q == ID_WIDTH'(i));
            comp_oh[i]  = comp_ok & (comp_id_i == ID_WIDTH'(i));
        end
    end

    assign gw.comp = comp_oh;

    // Same-ID claim+complete: act_q was clear, so comp_oh is 0 and the claim wins.
    assign ip_d      = (ip_q | (gw.valid & ready)) & ~claim_oh;
    assign act_d     = (act_q | claim_oh) & ~comp_oh;
    assign ext_irq_d = (best_prio_q > thold_i);

    plic_max_sel #(
        .N  (IRQ_NUM),
        .PW (IRQ_PRIO_WIDTH),
        .IW (ID_WIDTH)
    ) u_max_sel (
        .elig_i     (elig),
        .prio_i     (prio_i),
        .max_id_o   (best_id_d),
        .max_prio_o (best_prio_d)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ip_q        <= '0;
            act_q       <= '0;
            best_id_q   <= '0;
            best_prio_q <= '0;
            ext_irq_q   <= 1'b0;
        end else begin
            ip_q        <= ip_d;
            act_q       <= act_d;
            best_id_q   <= best_id_d;
            best_prio_q <= best_prio_d;
            ext_irq_q   <= ext_irq_d;
        end
    end

    assign ip_o      = ip_q;
    assign ext_irq_o = ext_irq_q;

endmodule

// File: tb/tb_plic_target_ctrl.sv
// Self-checking bench for plic_target_ctrl: directed scenarios plus random traffic vs a reference model.
module tb_plic_target_ctrl;
    import plic_pkg::*;

    localparam int N  = 3;
    localparam int PW = 3;
    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic [N-1:0][PW-1:0] prio;
    logic [N-1:0]       ie;
    logic [PW-1:0]      thold;
    logic               claim, comp;
    logic [IW-1:0]      comp_id;
    logic [N-1:0]       ip;
    logic [IW-1:0]      claim_id;
    logic               ext_irq;

    int n_cmp = 0;
    int n_err = 0;

    plic_target_ctrl_if #(.IRQ_NUM(N)) gw ();

    plic_target_ctrl #(.IRQ_NUM(N), .IRQ_PRIO_WIDTH(PW)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .gw         (gw),
        .prio_i     (prio),
        .ie_i       (ie),
        .thold_i    (thold),
        .ip_o       (ip),
        .claim_i    (claim),
        .claim_id_o (claim_id),
        .comp_i     (comp),
        .comp_id_i  (comp_id),
        .ext_irq_o  (ext_irq)
    );

    // Reference model: pending/in-flight sets, registered winner and interrupt line.
    bit m_ip [N];
    bit m_act[N];
    int m_best_id, m_best_prio;
    bit m_ext;

    function automatic bit m_elig(input int i);
        return m_ip[i] && ie[i] && (prio[i] != 0);
    endfunction

    function automatic int m_claim_id();
        if (!rst_n) return 0;
        if (m_best_prio > int'(thold) && m_elig(m_best_id)) return m_best_id;
        return 0;
    endfunction

    function automatic logic [N-1:0] m_comp();
        logic [N-1:0] r = '0;
        if (rst_n && comp && comp_id != 0 && int'(comp_id) < N && m_act[comp_id]) r[comp_id] = 1'b1;
        return r;
    endfunction

    function automatic logic [N-1:0] m_ip_vec();
        logic [N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[i] = m_ip[i];
        return r;
    endfunction

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r = '0;
        for (int i = 1; i < N; i++) r[i] = !m_ip[i];
        return r;
    endfunction

    task automatic tick();
        bit nip[N], nact[N];
        int cid, bp, bi;
        bit next_ext;
        logic [N-1:0] c;
        cid = claim ? m_claim_id() : 0;
        c   = m_comp();
        bp  = 0;
        bi  = 0;
        for (int i = 1; i < N; i++)
            if (m_elig(i) && int'(prio[i]) > bp) begin bp = int'(prio[i]); bi = i; end
        next_ext = (m_best_prio > int'(thold));
        for (int i = 0; i < N; i++) begin
            nip[i]  = (i != 0) && (m_ip[i] || gw.valid[i]) && (cid != i);
            nact[i] = (m_act[i] || (cid != 0 && cid == i)) && !c[i];
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            m_ip[i]  = rst_n ? nip[i]  : 1'b0;
            m_act[i] = rst_n ? nact[i] : 1'b0;
        end
        m_best_id   = rst_n ? bi : 0;
        m_best_prio = rst_n ? bp : 0;
        m_ext       = rst_n ? next_ext : 1'b0;
        @(negedge clk);
    endtask

    // Stimulus drivers only: one-cycle request pulse plus time for the resolver.
    task automatic pend(input logic [N-1:0] mask);
        gw.valid = mask;
        tick();
        gw.valid = '0;
        tick();
        tick();
    endtask

    task automatic complete(input int id);
        comp = 1'b1;
        comp_id = IW'(id);
        tick();
        comp = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; gw.valid = '0; prio = '0; ie = '0; thold = '0;
        claim = 1'b1; comp = 1'b0; comp_id = '0;
        tick();
        tick();
        #1;
        n_cmp++; if (ip !== 3'b000) begin n_err++; $display("FAIL reset_ip got=%b exp=000", ip); end
        n_cmp++; if (ext_irq !== 1'b0) begin n_err++; $display("FAIL reset_ext got=%b exp=0", ext_irq); end
        n_cmp++; if (claim_id !== 2'd0) begin n_err++; $display("FAIL reset_claim_id got=%0d exp=0", claim_id); end
        n_cmp++; if (gw.comp !== 3'b000) begin n_err++; $display("FAIL reset_comp got=%b exp=000", gw.comp); end
        rst_n = 1'b1;
        claim = 1'b0;
        #1;
        n_cmp++; if (gw.ready !== 3'b110) begin n_err++; $display("FAIL reset_ready got=%b exp=110", gw.ready); end
    endtask

    task automatic test_basic();
        prio = '0; prio[1] = 3'd2; ie = 3'b110; thold = '0;
        gw.valid = 3'b010;
        #1;
        n_cmp++; if (gw.ready[1] !== 1'b1) begin n_err++; $display("FAIL basic_ready_pre got=%b exp=1", gw.ready[1]); end
        tick();
        gw.valid = '0;
        #1;
        n_cmp++; if (ip !== 3'b010) begin n_err++; $display("FAIL basic_ip got=%b exp=010", ip); end
        n_cmp++; if (gw.ready !== 3'b100) begin n_err++; $display("FAIL basic_ready_post got=%b exp=100", gw.ready); end
        n_cmp++; if (ext_irq !== 1'b0) begin n_err++; $display("FAIL basic_ext_e1 got=%b exp=0", ext_irq); end
        tick();
        #1;
        n_cmp++; if (ext_irq !== 1'b0) begin n_err++; $display("FAIL basic_ext_e2 got=%b exp=0", ext_irq); end
        tick();
        #1;
        n_cmp++; if (ext_irq !== 1'b1) begin n_err++; $display("FAIL basic_ext_e3 got=%b exp=1", ext_irq); end
        claim = 1'b1;
        #1;
        n_cmp++; if (claim_id !== 2'd1) begin n_err++; $display("FAIL basic_claim got=%0d exp=1", claim_id); end
        tick();
        claim = 1'b0;
        #1;
        n_cmp++; if (ip !== 3'b000) begin n_err++; $display("FAIL basic_ip_clr got=%b exp=000", ip); end
        tick();
        #1;
        n_cmp++; if (ext_irq !== 1'b1) begin n_err++; $display("FAIL basic_ext_hold got=%b exp=1", ext_irq); end
        tick();
        #1;
        n_cmp++; if (ext_irq !== 1'b0) begin n_err++; $display("FAIL basic_ext_fall got=%b exp=0", ext_irq); end
        comp = 1'b1; comp_id = 2'd1;
        #1;
        n_cmp++; if (gw.comp !== 3'b010) begin n_err++; $display("FAIL comp_pulse got=%b exp=010", gw.comp); end
        tick();
        #1;
        n_cmp++; if (gw.comp !== 3'b000) begin n_err++; $display("FAIL comp_repeat got=%b exp=000", gw.comp); end
        comp_id = 2'd0;
        #1;
        n_cmp++; if (gw.comp !== 3'b000) begin n_err++; $display("FAIL comp_id0 got=%b exp=000", gw.comp); end
        comp_id = 2'd3;
        #1;
        n_cmp++; if (gw.comp !== 3'b000) begin n_err++; $display("FAIL comp_oor got=%b exp=000", gw.comp); end
        comp = 1'b0;
        tick();
    endtask

    task automatic test_tie();
        prio = '0; prio[1] = 3'd3; prio[2] = 3'd3; ie = 3'b110; thold = '0;
        pend(3'b110);
        claim = 1'b1;
        #1;
        n_cmp++; if (claim_id !== 2'd1) begin n_err++; $display("FAIL tie_first got=%0d exp=1", claim_id); end
        tick();
        #1;
        n_cmp++; if (claim_id !== 2'd0) begin n_err++; $display("FAIL tie_stale got=%0d exp=0", claim_id); end
        tick();
        #1;
        n_cmp++; if (claim_id !== 2'd2) begin n_err++; $display("FAIL tie_second got=%0d exp=2", claim_id); end
        tick();
        claim = 1'b0;
        complete(1);
        complete(2);
        prio[1] = 3'd2; prio[2] = 3'd5;
        pend(3'b110);
        claim = 1'b1;
        #1;
        n_cmp++; if (claim_id !== 2'd2) begin n_err++; $display("FAIL prio_first got=%0d exp=2", claim_id); end
        tick();
        tick();
        #1;
        n_cmp++; if (claim_id !== 2'd1) begin n_err++; $display("FAIL prio_second got=%0d exp=1", claim_id); end
        tick();
        claim = 1'b0;
        complete(1);
        complete(2);
    endtask

    task automatic test_thold();
        prio = '0; prio[1] = 3'd3; ie = 3'b110; thold = 3'd3;
        pend(3'b010);
        tick();
        #1;
        n_cmp++; if (ext_irq !== 1'b0) begin n_err++; $display("FAIL thold_eq_ext got=%b exp=0", ext_irq); end
        claim = 1'b1;
        #1;
        n_cmp++; if (claim_id !== 2'd0) begin n_err++; $display("FAIL thold_eq_claim got=%0d exp=0", claim_id); end
        tick();
        claim = 1'b0;
        #1;
        n_cmp++; if (ip !== 3'b010) begin n_err++; $display("FAIL thold_no_side_effect got=%b exp=010", ip); end
        thold = 3'd2;
        tick();
        #1;
        n_cmp++; if (ext_irq !== 1'b1) begin n_err++; $display("FAIL thold_lt_ext got=%b exp=1", ext_irq); end
        claim = 1'b1;
        #1;
        n_cmp++; if (claim_id !== 2'd1) begin n_err++; $display("FAIL thold_lt_claim got=%0d exp=1", claim_id); end
        tick();
        claim = 1'b0;
        complete(1);
        thold = '0;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        prio = '0; prio[2] = 3'd4; ie = 3'b110; thold = '0;
        pend(3'b100);
        claim = 1'b1;
        #1;
        n_cmp++; if (claim_id !== 2'd2) begin n_err++; $display("FAIL b2b_first got=%0d exp=2", claim_id); end
        tick();
        #1;
        n_cmp++; if (claim_id !== 2'd0) begin n_err++; $display("FAIL b2b_second got=%0d exp=0", claim_id); end
        tick();
        claim = 1'b0;
        #1;
        n_cmp++; if (ip !== 3'b000) begin n_err++; $display("FAIL b2b_ip got=%b exp=000", ip); end
        comp = 1'b1; comp_id = 2'd2;
        #1;
        n_cmp++; if (gw.comp !== 3'b100) begin n_err++; $display("FAIL b2b_comp got=%b exp=100", gw.comp); end
        tick();
        #1;
        n_cmp++; if (gw.comp !== 3'b000) begin n_err++; $display("FAIL b2b_comp_once got=%b exp=000", gw.comp); end
        comp = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_claim_comp();
        prio = '0; prio[1] = 3'd2; prio[2] = 3'd2; ie = 3'b110; thold = '0;
        pend(3'b010);
        claim = 1'b1;
        tick();
        claim = 1'b0;
        pend(3'b100);
        claim = 1'b1; comp = 1'b1; comp_id = 2'd1;
        #1;
        n_cmp++; if (claim_id !== 2'd2) begin n_err++; $display("FAIL cc_claim got=%0d exp=2", claim_id); end
        n_cmp++; if (gw.comp !== 3'b010) begin n_err++; $display("FAIL cc_comp got=%b exp=010", gw.comp); end
        tick();
        claim = 1'b0; comp = 1'b0;
        #1;
        n_cmp++; if (ip !== 3'b000) begin n_err++; $display("FAIL cc_ip got=%b exp=000", ip); end
        comp = 1'b1; comp_id = 2'd2;
        #1;
        n_cmp++; if (gw.comp !== 3'b100) begin n_err++; $display("FAIL cc_comp2 got=%b exp=100", gw.comp); end
        tick();
        comp = 1'b0;
        pend(3'b010);
        claim = 1'b1; comp = 1'b1; comp_id = 2'd1;
        #1;
        n_cmp++; if (claim_id !== 2'd1) begin n_err++; $display("FAIL same_claim got=%0d exp=1", claim_id); end
        n_cmp++; if (gw.comp !== 3'b000) begin n_err++; $display("FAIL same_comp got=%b exp=000", gw.comp); end
        tick();
        claim = 1'b0;
        #1;
        n_cmp++; if (gw.comp !== 3'b010) begin n_err++; $display("FAIL same_comp_after got=%b exp=010", gw.comp); end
        tick();
        comp = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        prio = '0; prio[1] = 3'd6; ie = 3'b110; thold = '0;
        pend(3'b010);
        tick();
        claim = 1'b1; rst_n = 1'b0;
        #1;
        n_cmp++; if (claim_id !== 2'd0) begin n_err++; $display("FAIL rstmid_claim got=%0d exp=0", claim_id); end
        tick();
        #1;
        n_cmp++; if (ip !== 3'b000) begin n_err++; $display("FAIL rstmid_ip got=%b exp=000", ip); end
        n_cmp++; if (ext_irq !== 1'b0) begin n_err++; $display("FAIL rstmid_ext got=%b exp=0", ext_irq); end
        n_cmp++; if (gw.comp !== 3'b000) begin n_err++; $display("FAIL rstmid_comp got=%b exp=000", gw.comp); end
        rst_n = 1'b1; claim = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 1; i < N; i++) prio[i] = PW'($urandom_range(0, 7));
        for (int cyc = 0; cyc < 600; cyc++) begin
            gw.valid = N'($urandom_range(0, 7));
            ie       = ($urandom_range(0, 7) != 0) ? 3'b110 : N'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) prio[$urandom_range(1, N-1)] = PW'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) thold = PW'($urandom_range(0, 4));
            claim   = ($urandom_range(0, 3) == 0);
            comp    = ($urandom_range(0, 2) == 0);
            comp_id = IW'($urandom_range(0, 3));
            rst_n   = ($urandom_range(0, 127) != 0);
            #1;
            n_cmp++; if (ip !== m_ip_vec()) begin n_err++; $display("FAIL rnd_ip cyc=%0d got=%b exp=%b", cyc, ip, m_ip_vec()); end
            n_cmp++; if (gw.ready !== m_ready()) begin n_err++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, gw.ready, m_ready()); end
            n_cmp++; if (ext_irq !== m_ext) begin n_err++; $display("FAIL rnd_ext cyc=%0d got=%b exp=%b", cyc, ext_irq, m_ext); end
            n_cmp++; if (claim_id !== IW'(m_claim_id())) begin n_err++; $display("FAIL rnd_claim cyc=%0d got=%0d exp=%0d", cyc, claim_id, m_claim_id()); end
            n_cmp++; if (gw.comp !== m_comp()) begin n_err++; $display("FAIL rnd_comp cyc=%0d got=%b exp=%b", cyc, gw.comp, m_comp()); end
            tick();
        end
        rst_n = 1'b1; claim = 1'b0; comp = 1'b0; gw.valid = '0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_thold();
        test_back_to_back();
        test_claim_comp();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
